spi_flash_reader: RTL and testbench

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_reader.sv | 159 +++++++++++++++
 tb/tb_spi_flash_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_reader
// Brief    : SPI mode-0 flash read engine. After EOS it drives the CCLK
//            priming pulses, then serves READ transactions. Optional macro
//            SPI_FLASH_FAST_READ_EN selects FAST READ (0x0B + 8 dummy clocks).
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_reader #(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             eos,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             cclk,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] c_opcode = 8'h0B;
`else
    localparam logic [7:0] c_opcode = 8'h03;
`endif
    localparam logic [7:0]   c_div_last = 8'(CLK_DIV - 1);
    localparam logic [LEN_W:0] c_byte_one = (LEN_W+1)'(1);

    typedef enum logic [3:0] {
        WAIT_EOS, PRIME, IDLE, CMD, ADDR, DUMMY, DATA, DESEL
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_div;
    logic             r_eos_meta, r_eos_sync;
    logic             r_cclk, r_cs_n, r_ready, r_valid, r_done;
    logic [31:0]      r_sh;
    logic [7:0]       r_rx;
    logic [4:0]       r_bit;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W:0]   r_byte;

    logic       w_tick, w_clocking, w_rise, w_fall, w_phase_end, w_last_byte;
    logic [4:0] w_bit_lim;

    assign w_tick      = (r_div == c_div_last);
    assign w_clocking  = (r_state == PRIME) || (r_state == CMD) || (r_state == ADDR) ||
                         (r_state == DUMMY) || (r_state == DATA);
    assign w_rise      = w_tick && w_clocking && !r_cclk;
    assign w_fall      = w_tick && w_clocking && r_cclk;
    assign w_phase_end = w_fall && (r_bit == w_bit_lim);
    // Byte counter is one bit wider than len so a full 2^LEN_W read terminates.
    assign w_last_byte = (r_byte == ({1'b0, r_len} + c_byte_one));

    always_comb begin
        w_bit_lim = 5'd8;
        case (r_state)
            PRIME:   w_bit_lim = 5'd3;
            ADDR:    w_bit_lim = 5'd24;
            default: w_bit_lim = 5'd8;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= WAIT_EOS;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_EOS: if (r_eos_sync)  w_state_nxt = PRIME;
            PRIME:    if (w_phase_end) w_state_nxt = IDLE;
            IDLE:     if (start)       w_state_nxt = CMD;
            CMD:      if (w_phase_end) w_state_nxt = ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
            ADDR:     if (w_phase_end) w_state_nxt = DUMMY;
            DUMMY:    if (w_phase_end) w_state_nxt = DATA;
`else
            ADDR:     if (w_phase_end) w_state_nxt = DATA;
`endif
            DATA:     if (w_phase_end && w_last_byte) w_state_nxt = DESEL;
            // First DESEL tick raises cs_n; four more ticks give two full CCLK periods.
            DESEL:    if (w_tick && (r_bit == 5'd4)) w_state_nxt = IDLE;
            default:  w_state_nxt = WAIT_EOS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_eos_meta <= 1'b0;
            r_eos_sync <= 1'b0;
            r_cclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_ready    <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_sh       <= '0;
            r_rx       <= '0;
            r_bit      <= '0;
            r_len      <= '0;
            r_byte     <= '0;
        end else begin
            r_eos_meta <= eos;
            r_eos_sync <= r_eos_meta;
            r_valid    <= 1'b0;
            r_done     <= (r_state == DESEL) && (w_state_nxt == IDLE);
            r_ready    <= (w_state_nxt == IDLE);

            // Divider restarts on leaving IDLE so cs_n leads the first edge by a half-period.
            if ((r_state == WAIT_EOS) || (r_state == IDLE) || w_tick) r_div <= '0;
            else                                                     r_div <= r_div + 8'd1;

            if (w_rise)      r_cclk <= 1'b1;
            else if (w_fall) r_cclk <= 1'b0;

            if (r_state == IDLE)                           r_bit <= '0;
            else if (w_phase_end)                          r_bit <= '0;
            else if (w_rise || ((r_state == DESEL) && w_tick)) r_bit <= r_bit + 5'd1;

            if ((r_state == IDLE) && start) begin
                r_sh   <= {c_opcode, addr};
                r_len  <= len;
                r_byte <= '0;
                r_cs_n <= 1'b0;
            end else begin
                if (w_fall) r_sh <= {r_sh[30:0], 1'b0};
                if ((r_state == DESEL) && w_tick) r_cs_n <= 1'b1;
            end

            if (w_rise && (r_state == DATA)) begin
                r_rx <= {r_rx[6:0], miso};
                if (r_bit == 5'd7) begin
                    r_valid <= 1'b1;
                    r_byte  <= r_byte + c_byte_one;
                end
            end
        end
    end

    assign ready    = r_ready;
    assign rd_data  = r_rx;
    assign rd_valid = r_valid;
    assign done     = r_done;
    assign cclk     = r_cclk;
    assign cs_n     = r_cs_n;
    assign mosi     = r_sh[31];

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_reader
// Brief    : Directed/randomised bench with a behavioural SPI flash model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_reader;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = 4;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam int         HDR_BITS = 40;
    localparam logic [7:0] OPCODE   = 8'h0B;
`else
    localparam int         HDR_BITS = 32;
    localparam logic [7:0] OPCODE   = 8'h03;
`endif

    logic             clk = 1'b0, rst_n = 1'b0, eos = 1'b0, start = 1'b0, miso = 1'b0;
    logic [23:0]      addr = '0;
    logic [LEN_W-1:0] len = '0;
    logic             ready, rd_valid, done, cclk, cs_n, mosi;
    logic [7:0]       rd_data;

    always #5 clk = ~clk;

    spi_flash_reader #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .eos(eos), .start(start), .addr(addr), .len(len),
        .ready(ready), .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
        .cclk(cclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    int total = 0, bad = 0;
    logic [7:0]  resp[$];
    logic [7:0]  got[$];
    logic [39:0] fl_hdr = '0;
    int fl_rise = 0, fl_mosi_bad = 0, fl_setup = 0, fl_idx = 0;
    int prime_pulses = 0, cs_fall_cnt = 0, done_cnt = 0;
    int cyc = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, desel_gap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Flash model: collects header bits, returns resp[] MSB first after the header.
    always @(negedge cs_n) begin
        cs_fall_cnt++;
        cs_fall_cyc = cyc;
        fl_rise = 0; fl_hdr = '0; fl_mosi_bad = 0; fl_setup = -1; miso = 1'b0;
    end
    always @(posedge cs_n) cs_rise_cyc = cyc;

    always @(posedge cclk) begin
        if (cs_n === 1'b0) begin
            if (fl_rise == 0) fl_setup = cyc - cs_fall_cyc;
            if (fl_rise < HDR_BITS) fl_hdr = {fl_hdr[38:0], mosi};
            else if (mosi !== 1'b0) fl_mosi_bad++;
            fl_rise++;
        end else begin
            prime_pulses++;
        end
    end

    always @(negedge cclk) begin
        if ((cs_n === 1'b0) && (fl_rise >= HDR_BITS)) begin
            fl_idx = fl_rise - HDR_BITS;
            if ((fl_idx / 8) < resp.size()) miso = resp[fl_idx / 8][7 - (fl_idx % 8)];
            else                             miso = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rd_valid === 1'b1) got.push_back(rd_data);
        if (done === 1'b1) begin
            done_cnt++;
            desel_gap = cyc - cs_rise_cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int budget);
        int t = 0;
        while ((ready !== 1'b1) && (t < budget)) begin
            @(negedge clk);
            t++;
        end
        chk("ready_timeout", 64'(ready), 64'd1);
    endtask

    task automatic fill_resp(input int n);
        resp.delete();
        for (int i = 0; i < n; i++) resp.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic check_bytes(input string tag, input int n);
        chk({tag, "_nbytes"}, 64'(got.size()), 64'(n));
        for (int i = 0; (i < n) && (i < got.size()); i++)
            chk($sformatf("%s_byte%0d", tag, i), 64'(got[i]), 64'(resp[i % resp.size()]));
    endtask

    // One complete read of n bytes from a; poke drives start while busy.
    task automatic run_txn(input string tag, input logic [23:0] a, input int n, input bit poke);
        int d0, f0, t;
        logic [39:0] exp_hdr;
        wait_ready(4000);
        got.delete();
        d0 = done_cnt; f0 = cs_fall_cnt;
        addr = a; len = LEN_W'(n - 1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_ready"}, 64'(ready), 64'd0);
        if (poke) begin
            repeat (40) @(negedge clk);
            start = 1'b1; addr = ~a;
            repeat (5) @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while ((done !== 1'b1) && (t < 5000)) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_ready_at_done"}, 64'(ready), 64'd1);
        @(negedge clk);
`ifdef SPI_FLASH_FAST_READ_EN
        exp_hdr = {OPCODE, a, 8'h00};
`else
        exp_hdr = {8'h00, OPCODE, a};
`endif
        chk({tag, "_hdr"}, 64'(fl_hdr), 64'(exp_hdr));
        chk({tag, "_cclk_cs_low"}, 64'(fl_rise), 64'(HDR_BITS + 8 * n));
        chk({tag, "_setup"}, 64'(fl_setup >= CLK_DIV), 64'd1);
        chk({tag, "_mosi_data"}, 64'(fl_mosi_bad), 64'd0);
        check_bytes(tag, n);
        chk({tag, "_desel_gap"}, 64'(desel_gap >= 4 * CLK_DIV), 64'd1);
        repeat (20) @(negedge clk);
        chk({tag, "_cs_falls"}, 64'(cs_fall_cnt - f0), 64'd1);
        chk({tag, "_dones"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0, f0, t, nd, done_cyc, n;

        // Reset values
        rst_n = 1'b0; eos = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 64'(cs_n), 64'd1);
        chk("rst_cclk", 64'(cclk), 64'd0);
        chk("rst_mosi", 64'(mosi), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        prime_pulses = 0; cs_fall_cnt = 0; done_cnt = 0;

        // No CCLK before EOS, then exactly three priming pulses with cs_n high
        repeat (7) @(negedge clk);
        chk("pre_eos_cclk", 64'(prime_pulses), 64'd0);
        chk("pre_eos_ready", 64'(ready), 64'd0);
        eos = 1'b1;
        wait_ready(300);
        chk("prime_pulses", 64'(prime_pulses), 64'd3);
        chk("prime_cs_n", 64'(cs_fall_cnt), 64'd0);

        resp = {8'hA5};
        run_txn("single", 24'h123456, 1, 1'b0);

        resp = {8'h01, 8'h02, 8'h03, 8'h04};
        run_txn("four", 24'(32'($urandom)), 4, 1'b1);

        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, 6);
            fill_resp(n);
            run_txn($sformatf("rand%0d", k), 24'(32'($urandom)), n, 1'b0);
        end

        fill_resp(2);
        run_txn("top_addr", 24'hFFFFFF, 2, 1'b0);

        fill_resp(1 << LEN_W);
        run_txn("max_len", 24'h000000, 1 << LEN_W, 1'b0);

        // eos dropping after IDLE must not disturb operation
        eos = 1'b0;
        repeat (10) @(negedge clk);
        fill_resp(3);
        run_txn("eos_low", 24'h0F0F0F, 3, 1'b0);

        // start held high: back-to-back reads, next accepted in the done cycle
        wait_ready(4000);
        resp = {8'h3C, 8'hC3};
        got.delete();
        d0 = done_cnt; f0 = cs_fall_cnt; nd = 0; done_cyc = 0; t = 0;
        addr = 24'hABCDEF; len = LEN_W'(1); start = 1'b1;
        while ((nd < 2) && (t < 5000)) begin
            @(negedge clk);
            t++;
            if (done === 1'b1) begin
                nd++;
                if (nd == 1) done_cyc = cyc;
                else         start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("b2b_dones", 64'(nd), 64'd2);
        chk("b2b_cs_falls", 64'(cs_fall_cnt - f0), 64'd2);
        chk("b2b_restart_gap", 64'(cs_fall_cyc - done_cyc), 64'd1);
        chk("b2b_done_cnt", 64'(done_cnt - d0), 64'd2);
        check_bytes("b2b", 4);

        // Reset during the second byte of an 8-byte read
        wait_ready(4000);
        fill_resp(8);
        got.delete();
        d0 = done_cnt;
        addr = 24'h445566; len = LEN_W'(7); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while ((got.size() < 1) && (t < 2000)) begin
            @(negedge clk);
            t++;
        end
        chk("mid_first_byte", 64'(got.size()), 64'd1);
        repeat (6) @(negedge clk);
        rst_n = 1'b0; eos = 1'b0;
        #1;
        chk("mid_rst_cs_n", 64'(cs_n), 64'd1);
        chk("mid_rst_cclk", 64'(cclk), 64'd0);
        chk("mid_rst_ready", 64'(ready), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        prime_pulses = 0;
        repeat (10) @(negedge clk);
        chk("mid_no_done", 64'(done_cnt - d0), 64'd0);
        chk("mid_wait_eos_cclk", 64'(prime_pulses), 64'd0);
        chk("mid_wait_eos_ready", 64'(ready), 64'd0);
        eos = 1'b1;
        wait_ready(300);
        chk("mid_prime_pulses", 64'(prime_pulses), 64'd3);

        fill_resp(2);
        run_txn("after_rst", 24'h000000, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
